// File: rtl/b16_pkg.sv
// Shared definitions for the b16 memory arbiter: state encoding and gap counter width.
package b16_pkg;

    typedef enum logic [1:0] {
        CPU  = 2'b00,
        HOST = 2'b01,
        DONE = 2'b10
    } arb_state_t;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

endpackage

// File: rtl/b16_mem_arb.sv
// Single-port memory arbiter: the CPU owns every slot, a host request steals one
// slot by freezing the core for that cycle, with a minimum CPU gap between steals.
//
// state | meaning
// ------+------------------------------------------------------------
// CPU   | memory port driven by the core, gap counter running
// HOST  | memory port driven by the latched host command, core frozen
// DONE  | core back on the port, h_ack pulses, gap counter held
module b16_mem_arb
    import b16_pkg::*;
#(
    parameter int l    = 16,
    parameter int cgap = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         run_in,
    output logic         cpu_run,
    input  logic [l-1:0] cpu_addr,
    input  logic         cpu_rd,
    input  logic [1:0]   cpu_wr,
    input  logic [l-1:0] cpu_dout,
    output logic [l-1:0] cpu_din,
    input  logic         h_req,
    input  logic [l-1:0] h_addr,
    input  logic [1:0]   h_we,
    input  logic [l-1:0] h_wdata,
    output logic         h_ack,
    output logic [l-1:0] h_rdata,
    output logic [l-1:0] mem_addr,
    output logic         mem_rd,
    output logic [1:0]   mem_wr,
    output logic [l-1:0] mem_wdata,
    input  logic [l-1:0] mem_rdata
);

    // cgap is compared against cnt+1, which needs one extra bit to hold 16.
    localparam logic [CNT_W:0] CGAP_V = (CNT_W+1)'(cgap);

    arb_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [l-1:0]     haddr_q;
    logic [1:0]       hwe_q;
    logic [l-1:0]     hwdata_q;

    logic             in_host;
    logic [CNT_W:0]   cnt_inc;
    logic             grant;

    assign in_host = (state_q == HOST);
    assign cnt_inc = {1'b0, cnt_q} + 1'b1;
    // A halted core does not need its gap protected, so the grant is immediate.
    assign grant   = h_req && ((cnt_inc >= CGAP_V) || !run_in);

    // Memory-port source select: pure 2:1 choice so the CPU path gains no register stage.
    always_comb begin
        cpu_run   = run_in;
        mem_addr  = cpu_addr;
        mem_rd    = cpu_rd;
        mem_wr    = cpu_wr;
        mem_wdata = cpu_dout;
        if (in_host) begin
            cpu_run   = 1'b0;
            mem_addr  = haddr_q;
            mem_rd    = (hwe_q == 2'b00);
            mem_wr    = hwe_q;
            mem_wdata = hwdata_q;
        end
    end

    assign cpu_din = mem_rdata;

    // Arbitration FSM with gap counter, command latch and registered host response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= CPU;
            cnt_q    <= '0;
            haddr_q  <= '0;
            hwe_q    <= '0;
            hwdata_q <= '0;
            h_ack    <= 1'b0;
            h_rdata  <= '0;
        end else begin
            h_ack <= 1'b0;
            case (state_q)
                CPU: begin
                    if (grant) begin
                        state_q  <= HOST;
                        cnt_q    <= '0;
                        haddr_q  <= h_addr;
                        hwe_q    <= h_we;
                        hwdata_q <= h_wdata;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOST: begin
                    state_q <= DONE;
                    h_ack   <= 1'b1;
                    if (hwe_q == 2'b00) begin
                        h_rdata <= mem_rdata;
                    end
                end
                DONE: begin
                    // The finished request is still high here, so it must not re-grant.
                    state_q <= CPU;
                end
                default: begin
                    state_q <= CPU;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_b16_mem_arb.sv
// Testbench for b16_mem_arb: bench-owned memory, slot-level reference model and directed scenarios.
module tb_b16_mem_arb;

    localparam int L    = 16;
    localparam int CGAP = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         run_in;
    logic         cpu_run;
    logic [L-1:0] cpu_addr;
    logic         cpu_rd;
    logic [1:0]   cpu_wr;
    logic [L-1:0] cpu_dout;
    logic [L-1:0] cpu_din;
    logic         h_req;
    logic [L-1:0] h_addr;
    logic [1:0]   h_we;
    logic [L-1:0] h_wdata;
    logic         h_ack;
    logic [L-1:0] h_rdata;
    logic [L-1:0] mem_addr;
    logic         mem_rd;
    logic [1:0]   mem_wr;
    logic [L-1:0] mem_wdata;
    logic [L-1:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    b16_mem_arb #(.l(L), .cgap(CGAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .run_in    (run_in),
        .cpu_run   (cpu_run),
        .cpu_addr  (cpu_addr),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_dout  (cpu_dout),
        .cpu_din   (cpu_din),
        .h_req     (h_req),
        .h_addr    (h_addr),
        .h_we      (h_we),
        .h_wdata   (h_wdata),
        .h_ack     (h_ack),
        .h_rdata   (h_rdata),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory: asynchronous read, byte writes on the clock edge, plus a preload port.
    logic [15:0] mem [0:1023];
    logic        pre_en;
    logic [9:0]  pre_addr;
    logic [15:0] pre_data;

    assign mem_rdata = mem[mem_addr[9:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else begin
            if (mem_wr[0]) mem[mem_addr[9:0]][7:0]  <= mem_wdata[7:0];
            if (mem_wr[1]) mem[mem_addr[9:0]][15:8] <= mem_wdata[15:8];
        end
    end

    // Slot-level model: which slot the host owns, CPU cycles since its last slot.
    int          m_gap;
    bit          m_host;
    bit          m_done;
    logic [15:0] m_rdata;
    logic [15:0] m_addr;
    logic [1:0]  m_we;
    logic [15:0] m_wdata;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_gap = 0; m_host = 0; m_done = 0;
            m_rdata = '0; m_addr = '0; m_we = '0; m_wdata = '0;
        end else if (m_host) begin
            m_host = 0;
            m_done = 1;
            if (m_we == 2'b00) m_rdata = mem[m_addr[9:0]];
        end else if (m_done) begin
            m_done = 0;
        end else if (h_req && ((m_gap + 1 >= CGAP) || !run_in)) begin
            m_host = 1;
            m_gap = 0;
            m_addr = h_addr; m_we = h_we; m_wdata = h_wdata;
        end else begin
            m_gap++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Every cycle out of reset, the DUT outputs must match the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("cpu_run",   32'(cpu_run),   32'(run_in && !m_host));
            chk("mem_addr",  32'(mem_addr),  32'(m_host ? m_addr : cpu_addr));
            chk("mem_rd",    32'(mem_rd),    32'(m_host ? (m_we == 2'b00) : cpu_rd));
            chk("mem_wr",    32'(mem_wr),    32'(m_host ? m_we : cpu_wr));
            chk("mem_wdata", 32'(mem_wdata), 32'(m_host ? m_wdata : cpu_dout));
            chk("h_ack",     32'(h_ack),     32'(m_done));
            chk("h_rdata",   32'(h_rdata),   32'(m_rdata));
            chk("cpu_din",   32'(cpu_din),   32'(mem_rdata));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic count_acks(input int n, output int acks);
        acks = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (h_ack) acks++;
        end
    endtask

    task automatic gap_run(input int n, input int spacing, input string nm);
        int t[$];
        for (int i = 0; i < n; i++) begin
            tick();
            if (h_ack) t.push_back(cyc);
        end
        chk({nm, "_count_ok"}, 32'(t.size() >= 3), 32'd1);
        for (int i = 1; i < t.size(); i++) begin
            chk({nm, "_spacing"}, 32'(t[i] - t[i-1]), 32'(spacing));
        end
    endtask

    initial begin
        int acks;
        bit seen;
        reset = 1'b1; run_in = 1'b1;
        cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 2'b00; cpu_dout = '0;
        h_req = 1'b0; h_addr = '0; h_we = 2'b00; h_wdata = '0;
        pre_en = 1'b1; pre_addr = 10'h200; pre_data = 16'hBEEF;
        tick();
        pre_addr = 10'h300; pre_data = 16'h5566;
        tick();
        pre_en = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_h_ack",   32'(h_ack),   32'd0);
        chk("rst_h_rdata", 32'(h_rdata), 32'h0);
        chk("rst_cpu_run", 32'(cpu_run), 32'd1);

        // Idle host: CPU owns the port, run follows the debugger.
        cpu_addr = 16'h0010; cpu_rd = 1'b1;
        tick();
        chk("idle_mem_addr", 32'(mem_addr), 32'h0010);
        chk("idle_cpu_run",  32'(cpu_run),  32'd1);
        run_in = 1'b0;
        #1;
        chk("idle_run_low", 32'(cpu_run), 32'd0);
        run_in = 1'b1;
        count_acks(8, acks);
        chk("idle_no_ack", 32'(acks), 32'd0);

        // Host read with the gap already met: HOST next cycle, ack the one after.
        h_req = 1'b1; h_addr = 16'h0200; h_we = 2'b00;
        tick();
        chk("rd_host_run",  32'(cpu_run),  32'd0);
        chk("rd_host_addr", 32'(mem_addr), 32'h0200);
        chk("rd_host_ack",  32'(h_ack),    32'd0);
        tick();
        chk("rd_done_ack",   32'(h_ack),   32'd1);
        chk("rd_done_rdata", 32'(h_rdata), 32'hBEEF);
        chk("rd_done_run",   32'(cpu_run), 32'd1);
        h_req = 1'b0;
        tick();
        chk("rd_ack_pulse", 32'(h_ack), 32'd0);

        // Host low-byte write while the frozen CPU holds a full-word write to the same address.
        cpu_rd = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        h_req = 1'b1; h_addr = 16'h0300; h_we = 2'b01; h_wdata = 16'h12AB;
        tick();
        chk("wr_host_run",  32'(cpu_run), 32'd0);
        chk("wr_host_mwr",  32'(mem_wr),  32'h1);
        cpu_addr = 16'h0300; cpu_wr = 2'b11; cpu_dout = 16'hCDEF;
        h_req = 1'b0;
        #1;
        chk("wr_host_mwr_cpu", 32'(mem_wr), 32'h1);
        tick();
        chk("wr_byte_only", 32'(mem[10'h300]), 32'h55AB);
        chk("wr_ack",       32'(h_ack),        32'd1);
        chk("wr_rdata_kept", 32'(h_rdata),     32'hBEEF);
        tick();
        chk("wr_cpu_lands", 32'(mem[10'h300]), 32'hCDEF);
        cpu_wr = 2'b00;

        // One-cycle request while the gap is unmet never transfers.
        h_req = 1'b1; h_addr = 16'h0200; h_we = 2'b00;
        tick();
        h_req = 1'b0;
        count_acks(8, acks);
        chk("drop_no_ack", 32'(acks), 32'd0);

        // Continuous requests: gap of CGAP CPU cycles, waived while halted.
        h_req = 1'b1;
        gap_run(40, 2 + CGAP, "gap_run");
        h_req = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        run_in = 1'b0; h_req = 1'b1;
        gap_run(20, 3, "gap_halt");
        h_req = 1'b0; run_in = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // Reset during the HOST cycle abandons the transfer.
        h_req = 1'b1; h_addr = 16'h0200; h_we = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            if (!cpu_run) seen = 1'b1;
        end
        chk("rst_host_reached", 32'(seen), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_ack",    32'(h_ack),    32'd0);
        chk("rst_mid_rdata",  32'(h_rdata),  32'h0);
        chk("rst_mid_run",    32'(cpu_run),  32'd1);
        chk("rst_mid_addr",   32'(mem_addr), 32'(cpu_addr));
        h_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        count_acks(6, acks);
        chk("rst_mid_no_ack", 32'(acks), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/b16_mem_arb.md
# b16_mem_arb

Single-port memory arbiter placed between the b16 `cpu` core, a host/DMA requester and the shared 16-bit program/data memory. The CPU owns every memory slot by default. A host transfer steals exactly one slot: the arbiter holds the CPU's `run` input low for that cycle, so the core freezes and then resumes with no loss of state. The arbiter enforces a minimum number of CPU slots between host slots. It also grants immediately when the CPU is halted by the debugger.

## Interface
- `l`, 16: data/address width.
- `cgap`, 1: minimum CPU-state cycles between host slots; legal range 1..15.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `run_in` in 1: run request from the debugger (`drun`).
- `cpu_run` out 1: gated run to the core's `run` input.
- `cpu_addr` in l: CPU address.
- `cpu_rd` in 1: CPU read strobe.
- `cpu_wr` in 2: CPU byte write enables; [1] is the high byte.
- `cpu_dout` in l: CPU write data.
- `cpu_din` out l: read data to the CPU; always equals `mem_rdata`.
- `h_req` in 1: host request; held high until `h_ack`.
- `h_addr` in l: host address.
- `h_we` in 2: host byte enables; 2'b00 means read.
- `h_wdata` in l: host write data.
- `h_ack` out 1: one-cycle completion pulse.
- `h_rdata` out l: read data; valid while `h_ack` is high.
- `mem_addr` out l, `mem_rd` out 1, `mem_wr` out 2, `mem_wdata` out l: memory port.
- `mem_rdata` in l: combinational (asynchronous) read data; memory writes occur on the `clk` edge.

## Operation
- States: CPU, HOST, DONE.
- **CPU state:** memory port = CPU signals; `cpu_run = run_in`.
- **HOST state:** memory port = latched host command.
  - `mem_rd = (hwe_q == 0)`, `mem_wr = hwe_q`.
  - `cpu_run = 0`.
  - CPU `rd`/`wr` never reach memory in this state.
- **DONE state:** memory port = CPU signals; `cpu_run = run_in`; `h_ack = 1`.
- **Transitions:**
  - CPU→HOST when `h_req && (cnt+1 >= cgap || !run_in)`. Otherwise stay in CPU.
  - HOST→DONE unconditionally.
  - DONE→CPU unconditionally. `h_req` is ignored in DONE because the old request is still high.
- **Gap counter `cnt`:** 4 bits.
  - Incremented each CPU-state cycle, saturating at 15.
  - Cleared on entry to HOST.
  - DONE does not count.
- **Command latch:** `h_addr`, `h_we` and `h_wdata` are captured into `haddr_q`, `hwe_q` and `hwdata_q` on the CPU→HOST edge. The host only needs its payload stable while `h_req` is high before the grant.
- **Read data:** `h_rdata` is registered from `mem_rdata` at the HOST→DONE edge. It holds its value until the next host read completes. A host write leaves `h_rdata` unchanged.
- **Request dropped early:**
  - `h_req` falling before the grant edge: no transfer.
  - `h_req` falling after the grant edge: the transfer completes and `h_ack` still pulses.
- **Throughput:** with `cgap` = 1, one host slot per 3 cycles at most (HOST, DONE, CPU).
- **`run_in` = 0:** the gap is waived, but a CPU state cycle is still required between transfers.

## Timing
- Reset values:
  - state CPU, `cnt` 0.
  - `h_ack` 0, `h_rdata` 0.
  - command latches 0.
  - `cpu_run` follows `run_in`.
- Reset asserted mid-transfer (state HOST or DONE):
  - The transfer is abandoned and no `h_ack` is issued.
  - The host must re-request after reset.
- Latency: `h_req` sampled high at the end of cycle n with the gap met → HOST in n+1 → `h_ack` and `h_rdata` in n+2.
- `cpu_run` is low in exactly the HOST cycles and no others.
- Host memory write takes effect at the HOST→DONE edge.
- All memory-port outputs are combinational from state plus the selected source. There are no extra register stages on the CPU path, so CPU timing is unchanged.

## Structure
- Shared package `b16_pkg`:
  - state encoding constants: CPU=2'b00, HOST=2'b01, DONE=2'b10.
  - width constant for `cnt`.
- No sub-module is needed. The address/data source selection is a 2:1 choice on the state and can reuse the existing `mux` (`sel` = in HOST, `atpg` tied 0).

## Test plan
- **Idle host:** `h_req`=0, CPU reads 0x0010 → `mem_addr`=0x0010, `cpu_run`=`run_in`, `h_ack` never asserts.
- **Host read:** memory[0x0200]=0xBEEF, `h_req` with `h_addr`=0x0200, `h_we`=0.
  - `cpu_run`=0 for exactly one cycle.
  - Two cycles after the request is sampled, `h_ack`=1 and `h_rdata`=0xBEEF.
- **Host byte write while CPU also writes:** `h_we`=2'b01, `h_wdata`=0x12AB at 0x0300, CPU `cpu_wr`=2'b11 to 0x0300 in the same HOST cycle.
  - Only the low byte becomes 0xAB.
  - The CPU write lands in its next `run` cycle.
- **Gap enforcement:** `cgap`=4, `h_req` held continuously → HOST slots spaced exactly 6 cycles apart (HOST, DONE, 4×CPU). With `run_in`=0 → spacing 3.
- **Reset and early drop:**
  - Reset asserted in the HOST cycle → no `h_ack`, state CPU, `h_rdata`=0.
  - `h_req` pulsed for one cycle while the gap is unmet → no transfer, no `h_ack`.
